sap_ram: RTL and testbench

- 16 x 8 program/data RAM for the SAP-1 computer.
- Sits directly downstream of the memory address register: it consumes the registered 4-bit address and sources or sinks bytes on the shared W-bus.
- A built-in program loader fills memory sequentially through a valid/ready handshake before run mode starts. This replaces the manual DIP-switch programming step.

---
 rtl/sap_pkg.sv | 40 ++++
 rtl/sap_ram_loader.sv | 75 +++++++
 rtl/sap_ram.sv | 73 +++++++
 tb/tb_sap_ram.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants, loader state encoding and the SAP-1 demo program image for sap_ram.
// The image is used at reset only when RAM_PRELOAD_EN is defined.
package sap_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

  typedef enum logic [1:0] {
    P_IDLE,
    P_FILL,
    P_DONE
  } load_state_t;

  typedef logic [DEPTH-1:0][DATA_W-1:0] image_t;

  // Demo program: A = mem[9] + mem[10], display it, halt.
  function automatic image_t build_preload();
    image_t img;
    img     = '0;
    img[0]  = {LDA, 4'h9};
    img[1]  = {ADD, 4'hA};
    img[2]  = {OUT, 4'h0};
    img[3]  = {HLT, 4'h0};
    img[9]  = 8'h05;
    img[10] = 8'h03;
    return img;
  endfunction

  localparam image_t PRELOAD_IMAGE = build_preload();

endpackage

// File: rtl/sap_ram_loader.sv
// Sequential program loader for sap_ram: accepts 16 bytes over a valid/ready handshake
// and presents them as a write bundle that the top muxes ahead of run-mode writes.
module sap_ram_loader
  import sap_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_prog_mode,
  input  logic              i_prog_valid,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic              o_prog_ready,
  output logic              o_prog_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  load_state_t       r_state;
  load_state_t       w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;
  logic              w_accept;

  assign w_accept = (r_state == P_FILL) && i_prog_mode && i_prog_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= P_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Leaving program mode always rewinds, so a re-entered load starts again at word 0.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    if (!i_prog_mode) begin
      w_state_next = P_IDLE;
      w_ptr_next   = '0;
    end else begin
      case (r_state)
        P_IDLE: begin
          w_state_next = P_FILL;
          w_ptr_next   = '0;
        end
        P_FILL: begin
          if (w_accept) begin
            if (r_ptr == LAST_ADDR) begin
              w_state_next = P_DONE;
            end else begin
              w_ptr_next = r_ptr + 1'b1;
            end
          end
        end
        P_DONE:  w_state_next = P_DONE;
        default: begin
          w_state_next = P_IDLE;
          w_ptr_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_prog_ready = (r_state == P_FILL);
    o_prog_done  = (r_state == P_DONE);
    o_wr_en      = w_accept;
    o_wr_addr    = r_ptr;
    o_wr_data    = i_prog_data;
  end

endmodule

// File: rtl/sap_ram.sv
// SAP-1 16x8 program/data RAM with registered read port, run-mode writes and a built-in loader.
// Define RAM_PRELOAD_EN to reset the array to the demo program instead of all zeros.
module sap_ram
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              debug,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              load_in,
  input  logic              enable_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_q;

  logic              w_ld_we;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused_debug;

  // Tracing hook only; it has no effect on the hardware.
  assign w_unused_debug = debug;

  sap_ram_loader u_loader (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_prog_mode  (prog_mode),
    .i_prog_valid (prog_valid),
    .i_prog_data  (prog_data),
    .o_prog_ready (prog_ready),
    .o_prog_done  (prog_done),
    .o_wr_en      (w_ld_we),
    .o_wr_addr    (w_ld_addr),
    .o_wr_data    (w_ld_data)
  );

  assign w_we    = w_ld_we | (load_in & ~prog_mode);
  assign w_waddr = w_ld_we ? w_ld_addr : address_in;
  assign w_wdata = w_ld_we ? w_ld_data : bus_in;

  // Read is sampled from the pre-write array, giving read-before-write on a shared address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef RAM_PRELOAD_EN
        r_mem[i] <= PRELOAD_IMAGE[i];
`else
        r_mem[i] <= '0;
`endif
      end
      r_rd_q <= '0;
    end else begin
      r_rd_q <= r_mem[address_in];
      if (w_we) begin
        r_mem[w_waddr] <= w_wdata;
      end
    end
  end

  assign bus_out = (enable_out && !prog_mode) ? r_rd_q : '0;

endmodule

// File: tb/tb_sap_ram.sv
// Self-checking bench for sap_ram: randomized run-mode traffic and loader scenarios
// checked against a word-array model of the RAM contents (honours RAM_PRELOAD_EN).
module tb_sap_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       debug;
  logic [3:0] address_in;
  logic       load_in;
  logic       enable_out;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       prog_mode;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [16];

  sap_ram dut (
    .clk        (clk),
    .rst        (rst),
    .debug      (debug),
    .address_in (address_in),
    .load_in    (load_in),
    .enable_out (enable_out),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) model[k] = 8'h00;
`ifdef RAM_PRELOAD_EN
    model[0]  = 8'h09;
    model[1]  = 8'h1A;
    model[2]  = 8'hE0;
    model[3]  = 8'hF0;
    model[9]  = 8'h05;
    model[10] = 8'h03;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0; debug = 1'b0; address_in = 4'd0; load_in = 1'b0; enable_out = 1'b1;
    bus_in = 8'h00; prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
    model_reset();
    #12;
    checks++;
    if (bus_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_bus_out: got %0h expected 00", bus_out); end
    checks++;
    if (prog_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_prog_ready: got %0b expected 0", prog_ready); end
    checks++;
    if (prog_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_prog_done: got %0b expected 0", prog_done); end
    @(negedge clk) rst = 1'b1;
    tick();
    address_in = 4'd5;
    tick();
    checks++;
    if (bus_out !== model[5]) begin errors++; $display("[TB] FAIL reset_read5: got %0h expected %0h", bus_out, model[5]); end
    address_in = 4'd1;
    tick();
    checks++;
    if (bus_out !== model[1]) begin errors++; $display("[TB] FAIL reset_read1: got %0h expected %0h", bus_out, model[1]); end
    address_in = 4'd9;
    tick();
    checks++;
    if (bus_out !== model[9]) begin errors++; $display("[TB] FAIL reset_read9: got %0h expected %0h", bus_out, model[9]); end
    enable_out = 1'b0;
    tick();
    checks++;
    if (bus_out !== 8'h00) begin errors++; $display("[TB] FAIL bus_idle: got %0h expected 00", bus_out); end
  endtask

  task automatic test_run_write();
    logic [7:0] old;
    address_in = 4'd3; bus_in = 8'hA5; load_in = 1'b1; enable_out = 1'b1;
    old = model[3];
    tick();
    checks++;
    if (bus_out !== old) begin errors++; $display("[TB] FAIL read_before_write: got %0h expected %0h", bus_out, old); end
    model[3] = 8'hA5;
    load_in = 1'b0;
    tick();
    checks++;
    if (bus_out !== 8'hA5) begin errors++; $display("[TB] FAIL write_visible: got %0h expected a5", bus_out); end
    enable_out = 1'b0;
  endtask

  task automatic test_random_run();
    logic [3:0] a;
    logic       wr;
    logic [7:0] d;
    for (int n = 0; n < 32; n++) begin
      a  = 4'($urandom_range(15));
      wr = 1'($urandom_range(1));
      d  = 8'($urandom);
      address_in = a; load_in = wr; bus_in = d; enable_out = 1'b1;
      tick();
      checks++;
      if (bus_out !== model[a]) begin errors++; $display("[TB] FAIL random_run[%0d] addr %0d: got %0h expected %0h", n, a, bus_out, model[a]); end
      if (wr) model[a] = d;
    end
    load_in = 1'b0; enable_out = 1'b0;
  endtask

  task automatic test_full_load();
    int loaded = 0;
    int readyCycles = 0;
    logic expReady;
    logic [7:0] d;
    prog_mode = 1'b1;
    tick();
    for (int cyc = 0; cyc < 17; cyc++) begin
      expReady = (loaded < 16);
      d = expReady ? 8'(8'h10 + loaded) : 8'hEE;
      prog_valid = 1'b1; prog_data = d;
      checks++;
      if (prog_ready !== expReady) begin errors++; $display("[TB] FAIL full_ready[%0d]: got %0b expected %0b", cyc, prog_ready, expReady); end
      if (prog_ready === 1'b1) readyCycles++;
      tick();
      if (expReady) begin model[loaded] = d; loaded++; end
    end
    checks++;
    if (readyCycles !== 16) begin errors++; $display("[TB] FAIL full_ready_count: got %0d expected 16", readyCycles); end
    checks++;
    if (prog_done !== 1'b1) begin errors++; $display("[TB] FAIL full_done: got %0b expected 1", prog_done); end
    prog_valid = 1'b0; prog_mode = 1'b0;
    tick();
    checks++;
    if (prog_done !== 1'b0) begin errors++; $display("[TB] FAIL full_done_clear: got %0b expected 0", prog_done); end
    for (int k = 0; k < 16; k++) begin
      address_in = 4'(k); enable_out = 1'b1;
      tick();
      checks++;
      if (bus_out !== model[k]) begin errors++; $display("[TB] FAIL full_readback[%0d]: got %0h expected %0h", k, bus_out, model[k]); end
    end
    enable_out = 1'b0;
  endtask

  task automatic test_gaps();
    int loaded = 0;
    int cyc = 0;
    prog_mode = 1'b1;
    tick();
    while (loaded < 16 && cyc < 100) begin
      prog_valid = (cyc % 2 == 0);
      prog_data  = 8'($urandom);
      checks++;
      if (prog_ready !== 1'b1) begin errors++; $display("[TB] FAIL gap_ready[%0d]: got %0b expected 1", cyc, prog_ready); end
      tick();
      if (prog_valid) begin model[loaded] = prog_data; loaded++; end
      cyc++;
    end
    checks++;
    if (loaded != 16) begin errors++; $display("[TB] FAIL gap_timeout: got %0d bytes expected 16", loaded); end
    for (int n = 0; n < 3; n++) begin
      prog_valid = 1'b1; prog_data = 8'($urandom);
      checks++;
      if (prog_ready !== 1'b0 || prog_done !== 1'b1) begin errors++; $display("[TB] FAIL gap_done_hold[%0d]: got ready %0b done %0b expected 0 1", n, prog_ready, prog_done); end
      tick();
    end
    prog_valid = 1'b0; prog_mode = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      address_in = 4'(k); enable_out = 1'b1;
      tick();
      checks++;
      if (bus_out !== model[k]) begin errors++; $display("[TB] FAIL gap_readback[%0d]: got %0h expected %0h", k, bus_out, model[k]); end
    end
    enable_out = 1'b0;
  endtask

  task automatic test_abort();
    prog_mode = 1'b1;
    tick();
    for (int n = 0; n < 6; n++) begin
      prog_valid = 1'b1; prog_data = 8'($urandom);
      tick();
      model[n] = prog_data;
    end
    prog_valid = 1'b0; prog_mode = 1'b0;
    tick();
    checks++;
    if (prog_ready !== 1'b0 || prog_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got ready %0b done %0b expected 0 0", prog_ready, prog_done); end
    prog_mode = 1'b1;
    tick();
    for (int n = 0; n < 16; n++) begin
      prog_valid = 1'b1; prog_data = 8'($urandom);
      tick();
      model[n] = prog_data;
    end
    prog_valid = 1'b0;
    checks++;
    if (prog_done !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload_done: got %0b expected 1", prog_done); end
    address_in = 4'd3; bus_in = ~model[3]; load_in = 1'b1; enable_out = 1'b1;
    tick();
    checks++;
    if (bus_out !== 8'h00) begin errors++; $display("[TB] FAIL prog_bus_quiet: got %0h expected 00", bus_out); end
    load_in = 1'b0; prog_mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      address_in = 4'(k);
      tick();
      checks++;
      if (bus_out !== model[k]) begin errors++; $display("[TB] FAIL abort_readback[%0d]: got %0h expected %0h", k, bus_out, model[k]); end
    end
    enable_out = 1'b0;
  endtask

  task automatic test_async_reset();
    prog_mode = 1'b1;
    tick();
    for (int n = 0; n < 8; n++) begin
      prog_valid = 1'b1; prog_data = 8'($urandom);
      tick();
    end
    prog_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (prog_ready !== 1'b0 || prog_done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ready: got ready %0b done %0b expected 0 0", prog_ready, prog_done); end
    model_reset();
    prog_mode = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    checks++;
    if (prog_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_idle: got %0b expected 0", prog_ready); end
    prog_mode = 1'b1;
    tick();
    checks++;
    if (prog_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_refill: got %0b expected 1", prog_ready); end
    prog_valid = 1'b1; prog_data = 8'($urandom);
    tick();
    model[0] = prog_data;
    prog_valid = 1'b0; prog_mode = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      address_in = 4'(k); enable_out = 1'b1;
      tick();
      checks++;
      if (bus_out !== model[k]) begin errors++; $display("[TB] FAIL async_readback[%0d]: got %0h expected %0h", k, bus_out, model[k]); end
    end
    enable_out = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_run_write();
    test_random_run();
    test_full_load();
    test_gaps();
    test_abort();
    test_random_run();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
